// File: rtl/affine_tap_accumulator_if.sv
// Product-in / sample-out stream bundle for the tap accumulator.
// master drives products and out_ready; slave is the accumulator.
interface affine_tap_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int OUT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_sample;

  modport master (
    output in_valid,
    output in_prod,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sample
  );

  modport slave (
    input  in_valid,
    input  in_prod,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sample
  );
endinterface

// File: rtl/affine_tap_accumulator.sv
// Tap-serial accumulator: sums TAPS products, rounds half-up,
// shifts and saturates into a one-entry valid/ready output register.
module affine_tap_accumulator #(
  parameter int TAPS   = 8,
  parameter int PROD_W = 16,
  parameter int ACC_W  = 20,
  parameter int SHIFT  = 6,
  parameter int OUT_W  = 8
) (
  input logic clk,
  input logic rst,
  affine_tap_accumulator_if.slave b
);

  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;

  localparam logic [CNT_W-1:0] LAST_TAP =
    CNT_W'(TAPS - 1);

  localparam logic signed [ACC_W:0] RND =
    (ACC_W+1)'(64'(1) << (SHIFT - 1));

  localparam logic signed [ACC_W:0] MAXV =
    (ACC_W+1)'((64'(1) << (OUT_W - 1)) - 64'(1));

  // ~(2^k - 1) == -2^k in two's complement
  localparam logic signed [ACC_W:0] MINV = ~MAXV;

  logic [CNT_W-1:0]        tap_cnt;
  logic signed [ACC_W-1:0] acc;
  logic                    out_valid_q;
  logic [OUT_W-1:0]        out_sample_q;

  logic                    last;
  logic                    in_ready;
  logic                    fire;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   shr;
  logic [OUT_W-1:0]        sat;

  assign last     = (tap_cnt == LAST_TAP);
  assign in_ready = !(last && out_valid_q && !b.out_ready);
  assign fire     = b.in_valid && in_ready;

  assign b.in_ready   = in_ready;
  assign b.out_valid  = out_valid_q;
  assign b.out_sample = out_sample_q;

  // Sign-extend, close the group, round, normalise and clip
  always_comb begin
    prod_ext = {{(ACC_W-PROD_W){b.in_prod[PROD_W-1]}},
                b.in_prod};
    sum = acc + prod_ext;
    rnd = {sum[ACC_W-1], sum} + RND;
    shr = rnd >>> SHIFT;
    sat = shr[OUT_W-1:0];
    if (shr > MAXV) begin
      sat = MAXV[OUT_W-1:0];
    end else if (shr < MINV) begin
      sat = MINV[OUT_W-1:0];
    end
  end

  // Tap counter, accumulator and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_cnt      <= '0;
      acc          <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
    end else begin
      if (out_valid_q && b.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (fire) begin
        if (last) begin
          out_valid_q  <= 1'b1;
          out_sample_q <= sat;
          acc          <= '0;
          tap_cnt      <= '0;
        end else begin
          acc     <= sum;
          tap_cnt <= tap_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_affine_tap_accumulator.sv
// Bench for affine_tap_accumulator: directed spot values plus
// randomized traffic against a queue-based reference model.
module tb_affine_tap_accumulator;

  localparam int TAPS   = 8;
  localparam int PROD_W = 16;
  localparam int SHIFT  = 6;
  localparam int OUT_W  = 8;

  logic clk;
  logic rst;

  affine_tap_accumulator_if #(
    .PROD_W(PROD_W),
    .OUT_W (OUT_W)
  ) bus ();

  affine_tap_accumulator dut (
    .clk(clk),
    .rst(rst),
    .b  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending products of the open group,
  // expected output register contents.
  int q[$];
  bit ev;
  int es;
  bit started = 0;

  function automatic int ref_sample(int prods[$]);
    longint s;
    longint n;
    longint r;
    longint hi;
    longint lo;
    s = 0;
    foreach (prods[i]) s += prods[i];
    n = s + (64'sd1 <<< (SHIFT - 1));
    // floor division by 2^SHIFT
    if (n >= 0) r = n / (64'sd1 <<< SHIFT);
    else r = -((-n + (64'sd1 <<< SHIFT) - 1) / (64'sd1 <<< SHIFT));
    hi = (64'sd1 <<< (OUT_W - 1)) - 1;
    lo = -(64'sd1 <<< (OUT_W - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return int'(r);
  endfunction

  function automatic bit mdl_ready();
    return !(q.size() == TAPS - 1 && ev && !bus.out_ready);
  endfunction

  // Advance the model on each rising edge
  always @(posedge clk) begin
    bit rdy;
    started <= 1'b1;
    if (rst) begin
      q.delete();
      ev = 1'b0;
      es = 0;
    end else begin
      rdy = mdl_ready();
      if (ev && bus.out_ready) ev = 1'b0;
      if (bus.in_valid && rdy) begin
        q.push_back(int'($signed(bus.in_prod)));
        if (q.size() == TAPS) begin
          es = ref_sample(q);
          ev = 1'b1;
          q.delete();
        end
      end
    end
  end

  // Compare DUT against the model every cycle
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (bus.in_ready !== mdl_ready()) begin
        errors++;
        $display("FAIL in_ready: got %0b expected %0b at %0t",
                 bus.in_ready, mdl_ready(), $time);
      end
      checks++;
      if (bus.out_valid !== ev) begin
        errors++;
        $display("FAIL out_valid: got %0b expected %0b at %0t",
                 bus.out_valid, ev, $time);
      end
      checks++;
      if ($isunknown(bus.out_sample) ||
          int'($signed(bus.out_sample)) != es) begin
        errors++;
        $display("FAIL out_sample: got %0d expected %0d at %0t",
                 $signed(bus.out_sample), es, $time);
      end
    end
  end

  task automatic lit(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one product and hold it until accepted
  task automatic send(int v);
    bit ok;
    int guard;
    bus.in_valid = 1'b1;
    bus.in_prod  = PROD_W'(v);
    guard = 0;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      step();
      guard++;
    end while (!ok && guard < 50);
    if (!ok) lit("send_timeout", guard, 0);
    bus.in_valid = 1'b0;
  endtask

  task automatic group(int v);
    for (int i = 0; i < TAPS; i++) send(v);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    lit("reset_in_ready", int'(bus.in_ready), 1);
    lit("reset_out_valid", int'(bus.out_valid), 0);
    lit("reset_out_sample", int'($signed(bus.out_sample)), 0);

    group(16);
    lit("pos_round_valid", int'(bus.out_valid), 1);
    lit("pos_round", int'($signed(bus.out_sample)), 2);
    step();

    group(-88);
    lit("neg_round", int'($signed(bus.out_sample)), -11);
    step();

    group(2000);
    lit("sat_hi", int'($signed(bus.out_sample)), 127);
    step();
    group(-2000);
    lit("sat_lo", int'($signed(bus.out_sample)), -128);
    step();

    // Backpressure with overlapping next group
    bus.out_ready = 1'b0;
    group(16);
    for (int i = 0; i < TAPS - 1; i++) send(-88);
    lit("bp_held", int'($signed(bus.out_sample)), 2);
    bus.in_valid = 1'b1;
    bus.in_prod  = PROD_W'(-88);
    @(negedge clk);
    lit("bp_stall", int'(bus.in_ready), 0);
    step();
    @(negedge clk);
    lit("bp_still_held", int'($signed(bus.out_sample)), 2);
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    lit("bp_release", int'(bus.in_ready), 1);
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    lit("bp_no_gap", int'(bus.out_valid), 1);
    lit("bp_second", int'($signed(bus.out_sample)), -11);
    step();
    bus.out_ready = 1'b1;
    step();

    // Back-to-back groups
    for (int g = 0; g < 3; g++) begin
      group(64);
      lit("b2b_valid", int'(bus.out_valid), 1);
      lit("b2b_sample", int'($signed(bus.out_sample)), 8);
    end
    step();

    // Reset mid-group
    for (int i = 0; i < 3; i++) send(1000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    lit("midrst_valid", int'(bus.out_valid), 0);
    group(16);
    lit("midrst_sample", int'($signed(bus.out_sample)), 2);
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) != 0)
        bus.in_prod = PROD_W'(int'($urandom_range(0, 65535)) - 32768);
      else
        bus.in_prod = PROD_W'(int'($urandom_range(0, 400)) - 200);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/affine_tap_accumulator.md
# affine_tap_accumulator

Tap-serial accumulation stage sitting directly downstream of the affine-filter MCM coefficient blocks. Each cycle it consumes one signed coefficient×sample product, sums TAPS consecutive products into one filtered value, then applies round-to-nearest, an arithmetic right shift and saturation. It presents the interpolated sample on a valid/ready output with a one-entry output register. This register lets accumulation of the next sample overlap with output backpressure.

## Interface
Parameters:
- TAPS, 8, products summed per output sample (≥2)
- PROD_W, 16, width of incoming signed product
- ACC_W, 20, accumulator width; must satisfy ACC_W ≥ PROD_W + clog2(TAPS) + 1
- SHIFT, 6, normalisation right shift (≥1)
- OUT_W, 8, signed output sample width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  in_prod holds a valid product
- in_ready  out  1  block accepts in_prod this cycle
- in_prod  in  PROD_W  signed product, tap order 0..TAPS-1
- out_valid  out  1  out_sample valid
- out_ready  in  1  downstream accepts out_sample
- out_sample  out  OUT_W  signed, rounded, saturated filtered sample

## Operation
- Accept: a product is consumed when in_valid && in_ready.
- Internal state:
  - tap_cnt: 0..TAPS-1
  - acc: ACC_W signed
  - out register: out_valid, out_sample
- Non-final tap (tap_cnt < TAPS-1) accepted:
  - acc ← acc + sext(in_prod)
  - tap_cnt ← tap_cnt + 1
- Final tap (tap_cnt == TAPS-1) accepted:
  - sum = acc + sext(in_prod)
  - r = (sum + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift; this is round-half-up, e.g. -10.5 → -10.
  - out_sample ← clip(r, -2^(OUT_W-1), 2^(OUT_W-1)-1)
  - out_valid ← 1
  - acc ← 0; tap_cnt ← 0 (wrap-around)
- Output accept:
  - out_valid && out_ready with no new final tap in the same cycle → out_valid ← 0.
  - A final tap accepted in the same cycle as out_ready overwrites the register; out_valid stays 1 and no bubble is inserted.
- in_ready = !(tap_cnt == TAPS-1 && out_valid && !out_ready).
  - Only the final tap stalls; taps 0..TAPS-2 are always accepted, even while the output is held.
  - in_ready is combinational from state and out_ready only; no dependency on in_valid.
- out_sample and out_valid are stable while out_valid && !out_ready.
- The block has no internal overflow; the width rule guarantees sum fits in ACC_W.

## Timing
- Reset values:
  - in_ready = 1 (after reset)
  - out_valid = 0
  - out_sample = 0
  - acc = 0
  - tap_cnt = 0
- Reset mid-group discards partial taps and any pending output; the next accepted product is tap 0.
- rst has priority over every accept in the same cycle.
- Latency: final tap accepted at edge N → out_valid = 1 and out_sample valid from edge N (visible in cycle N+1).
- Throughput: one sample per TAPS cycles with continuous in_valid and out_ready = 1.
- An idle in_valid = 0 mid-group holds acc and tap_cnt unchanged, for any duration.

## Test plan
- Rounding, positive: eight products of 16, defaults → sum 128, (128+32)>>>6 = 2. out_sample = 2; out_valid rises the cycle after the 8th accept.
- Rounding, negative: eight products of -88 → sum -704, (-704+32)>>>6 = -11 (floor of -10.5). out_sample = -11 (0xF5).
- Saturation: eight products of 2000 → r = 250 → out_sample = 127. Eight products of -2000 → r = -250 → out_sample = -128.
- Backpressure: first group yields out_valid with out_ready = 0; a second group streams in.
  - Taps 0..6 are accepted.
  - At tap 7, in_ready = 0 and out_sample holds the first result.
  - Raising out_ready for one cycle accepts tap 7 in that same cycle; out_valid stays 1 with the second result and no gap.
- Back-to-back: 24 consecutive products (three groups of eight, each 8×64) with out_ready = 1 → out_sample = 8 at cycles 8, 16, 24 after start; in_ready never drops.
- Reset mid-operation: accept 3 products of 1000, assert rst one cycle, then 8 products of 16 → out_sample = 2; no output from the partial group.
